// File: rtl/cmp_sort_if.sv
// Sample-stream bundle for the sort engine: producer side (in_*), consumer side (out_*)
// and status. The engine takes the slave modport; the producer/consumer takes master.
interface cmp_sort_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic [7:0]   cmp_cycles;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy, cmp_cycles
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, busy, cmp_cycles
    );
endinterface

// File: rtl/cmp_sort_engine.sv
// Loads a burst of up to DEPTH samples, bubble-sorts it in place using a single shared
// unsigned comparator (one compare per clock), then streams it out in ascending order.
module cmp_sort_engine #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    cmp_sort_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_reg;
    logic [W-1:0]  sbuf [DEPTH];
    logic [CW-1:0] count_reg;
    logic [CW-1:0] n_reg;
    logic [CW-1:0] pass_reg;
    logic [IW-1:0] idx_reg;
    logic [IW-1:0] rd_reg;
    logic          swapped_reg;
    logic          prime_reg;

    logic          in_ready_reg;
    logic          out_valid_reg;
    logic          out_last_reg;
    logic          busy_reg;
    logic [W-1:0]  out_data_reg;
    logic [7:0]    cmp_cycles_reg;

    logic [IW-1:0] idx_inc;
    logic [IW-1:0] rd_inc;
    logic [W-1:0]  cmp_a;
    logic [W-1:0]  cmp_b;
    logic          gr;
    logic          accept;
    logic          load_end;
    logic          compare;
    logic          pass_end;
    logic          sort_done;

    assign idx_inc = idx_reg + IW'(1);
    assign rd_inc  = rd_reg + IW'(1);

    // The one shared comparator; equal operands never swap, keeping the sort stable.
    assign cmp_a = sbuf[idx_reg];
    assign cmp_b = sbuf[idx_inc];
    assign gr    = cmp_a > cmp_b;

    assign accept    = (state_reg == LOAD) && in_ready_reg && bus.in_valid;
    assign load_end  = accept && (bus.in_last || (count_reg == CW'(DEPTH - 1)));
    assign compare   = (state_reg == SORT) && !prime_reg;
    assign pass_end  = (idx_reg == IW'(n_reg - CW'(2)));
    assign sort_done = pass_end &&
                       (!(swapped_reg || gr) || ((pass_reg + CW'(1)) == (n_reg - CW'(1))));

    // Sample storage has no reset: contents are meaningless until a burst is loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            sbuf[count_reg[IW-1:0]] <= bus.in_data;
        end else if (compare && gr) begin
            sbuf[idx_reg] <= cmp_b;
            sbuf[idx_inc] <= cmp_a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= LOAD;
            count_reg      <= '0;
            n_reg          <= '0;
            pass_reg       <= '0;
            idx_reg        <= '0;
            rd_reg         <= '0;
            swapped_reg    <= 1'b0;
            prime_reg      <= 1'b0;
            in_ready_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            out_data_reg   <= '0;
            cmp_cycles_reg <= '0;
        end else begin
            case (state_reg)
                LOAD: begin
                    in_ready_reg <= 1'b1;
                    if (accept) begin
                        count_reg <= count_reg + CW'(1);
                    end
                    if (load_end) begin
                        state_reg      <= SORT;
                        in_ready_reg   <= 1'b0;
                        busy_reg       <= 1'b1;
                        n_reg          <= count_reg + CW'(1);
                        pass_reg       <= '0;
                        idx_reg        <= '0;
                        swapped_reg    <= 1'b0;
                        prime_reg      <= 1'b1;
                        cmp_cycles_reg <= '0;
                    end
                end

                SORT: begin
                    // First SORT cycle is a setup slot; a single-sample burst leaves from it.
                    if (prime_reg) begin
                        prime_reg <= 1'b0;
                        if (n_reg == CW'(1)) begin
                            state_reg     <= DRAIN;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= 1'b1;
                            out_data_reg  <= sbuf[0];
                            rd_reg        <= '0;
                        end
                    end else begin
                        cmp_cycles_reg <= (cmp_cycles_reg == 8'hFF) ? 8'hFF
                                                                    : cmp_cycles_reg + 8'd1;
                        if (sort_done) begin
                            state_reg     <= DRAIN;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= 1'b0;
                            // A swap on this very compare has not reached sbuf[0] yet.
                            out_data_reg  <= ((idx_reg == '0) && gr) ? cmp_b : sbuf[0];
                            rd_reg        <= '0;
                        end else if (pass_end) begin
                            idx_reg     <= '0;
                            pass_reg    <= pass_reg + CW'(1);
                            swapped_reg <= 1'b0;
                        end else begin
                            idx_reg     <= idx_inc;
                            swapped_reg <= swapped_reg | gr;
                        end
                    end
                end

                DRAIN: begin
                    if (out_valid_reg && bus.out_ready) begin
                        if (out_last_reg) begin
                            state_reg     <= LOAD;
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            busy_reg      <= 1'b0;
                            count_reg     <= '0;
                            in_ready_reg  <= 1'b1;
                        end else begin
                            rd_reg       <= rd_inc;
                            out_data_reg <= sbuf[rd_inc];
                            out_last_reg <= (CW'(rd_inc) == (n_reg - CW'(1)));
                        end
                    end
                end

                default: begin
                    state_reg <= LOAD;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_reg;
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.out_data   = out_data_reg;
    assign bus.busy       = busy_reg;
    assign bus.cmp_cycles = cmp_cycles_reg;
endmodule

// File: tb/tb_cmp_sort_engine.sv
// Directed bench for cmp_sort_engine: reset behaviour, sort results, compare counts,
// latency and input stalling while a burst is being sorted and drained.
module tb_cmp_sort_engine;
    logic clk;
    logic rst;
    int   cyc;
    int   acc_cyc;
    int   checks;
    int   failures;

    logic [7:0] stim_q[$];
    logic [7:0] exp_q[$];

    cmp_sort_if #(.W(8)) bus ();

    cmp_sort_engine #(.DEPTH(8), .W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic load_burst(input bit use_last);
        int g;
        for (int k = 0; k < stim_q.size(); k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[k];
            bus.in_last  = use_last && (k == stim_q.size() - 1);
            g = 0;
            while (!bus.in_ready && g < 100) begin
                @(posedge clk); #1; g++;
            end
            if (!bus.in_ready) begin
                checks++; failures++;
                $display("FAIL load_timeout sample=%0d in_ready=%b required=1", k, bus.in_ready);
            end
            @(posedge clk); #1;
            acc_cyc = cyc;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        int g;
        g = 0;
        while (!bus.out_valid && g < 500) begin
            @(posedge clk); #1; g++;
        end
        lat = cyc - acc_cyc;
        if (!bus.out_valid) begin
            checks++; failures++;
            $display("FAIL out_valid_timeout out_valid=%b required=1", bus.out_valid);
        end
    endtask

    task automatic drain_check(input string name, input bit bp);
        int k;
        int g;
        k = 0;
        g = 0;
        while (k < exp_q.size() && g < 2000) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_data !== exp_q[k] || bus.out_last !== (k == exp_q.size() - 1)) begin
                    failures++;
                    $display("FAIL %s_out[%0d] data=%0d last=%b required data=%0d last=%b",
                             name, k, bus.out_data, bus.out_last, exp_q[k],
                             (k == exp_q.size() - 1));
                end
                k++;
            end
            @(posedge clk); #1; g++;
        end
        bus.out_ready = 1'b0;
        if (k < exp_q.size()) begin
            checks++; failures++;
            $display("FAIL %s_drain_timeout got=%0d required=%0d", name, k, exp_q.size());
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_after_drain out_valid=%b busy=%b required 0 0",
                     name, bus.out_valid, bus.busy);
        end
        $display("transaction %s: drained %0d samples", name, k);
    endtask

    task automatic sort_case(input string name, input int exp_cmp, input int exp_lat);
        int lat;
        load_burst(1'b1);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_sorting in_ready=%b busy=%b required 0 1", name, bus.in_ready, bus.busy);
        end
        wait_valid(lat);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency cycles=%0d required=%0d", name, lat, exp_lat);
        end
        checks++;
        if (bus.cmp_cycles !== 8'(exp_cmp)) begin
            failures++;
            $display("FAIL %s_cmp_cycles got=%0d required=%0d", name, bus.cmp_cycles, exp_cmp);
        end
        drain_check(name, 1'b0);
    endtask

    task automatic test_reset();
        int lat;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.cmp_cycles !== 8'd0 || bus.out_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_outputs in_ready=%b out_valid=%b out_last=%b busy=%b cmp=%0d data=%0d required all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.cmp_cycles, bus.out_data);
        end
        rst = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready in_ready=%b required=0", bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_edge_ready in_ready=%b required=1", bus.in_ready);
        end

        // Abort in the middle of DRAIN with the consumer stalled.
        stim_q = '{8'd7, 8'd2, 8'd9};
        load_burst(1'b1);
        wait_valid(lat);
        bus.out_ready = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.busy !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_drain out_valid=%b out_last=%b busy=%b in_ready=%b required all 0",
                     bus.out_valid, bus.out_last, bus.busy, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_recover in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        $display("transaction reset: power-on and mid-drain abort");
    endtask

    task automatic test_presorted();
        stim_q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        exp_q  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        sort_case("presorted", 7, 8);
    endtask

    task automatic test_reversed();
        stim_q = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        exp_q  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        sort_case("reversed", 49, 50);
    endtask

    task automatic test_duplicates();
        // Passes 1-3 each swap; pass 4 finds no swaps: 4 passes x 4 compares.
        stim_q = '{8'd5, 8'd3, 8'd5, 8'd0, 8'd3};
        exp_q  = '{8'd0, 8'd3, 8'd3, 8'd5, 8'd5};
        sort_case("duplicates", 16, 17);
    endtask

    task automatic test_single();
        stim_q = '{8'hAB};
        exp_q  = '{8'hAB};
        sort_case("single", 0, 1);
    endtask

    task automatic test_back_to_back();
        int lat;
        stim_q = '{8'd200, 8'd17, 8'd99, 8'd17, 8'd0, 8'd255, 8'd128, 8'd64};
        exp_q  = '{8'd0, 8'd17, 8'd17, 8'd64, 8'd99, 8'd128, 8'd200, 8'd255};
        load_burst(1'b0);
        // Ninth sample presented immediately; it must wait for the whole drain.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd42;
        bus.in_last  = 1'b1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL overflow_stall in_ready=%b busy=%b required 0 1", bus.in_ready, bus.busy);
        end
        wait_valid(lat);
        checks++;
        if (bus.cmp_cycles === 8'd0) begin
            failures++;
            $display("FAIL overflow_cmp_cycles got=%0d required nonzero", bus.cmp_cycles);
        end
        drain_check("overflow", 1'b1);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ninth_ready in_ready=%b required=1", bus.in_ready);
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        exp_q = '{8'd42};
        wait_valid(lat);
        checks++;
        if (lat != 1 || bus.cmp_cycles !== 8'd0) begin
            failures++;
            $display("FAIL ninth_burst latency=%0d cmp=%0d required 1 0", lat, bus.cmp_cycles);
        end
        drain_check("ninth", 1'b1);
    endtask

    initial begin
        rst           = 1'b1;
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        acc_cyc       = 0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        test_reset();
        test_presorted();
        test_reversed();
        test_duplicates();
        test_single();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
